// File: rtl/bus_mailbox_target.sv
// Memory-mapped 16-bit mailbox on the RDN/WR0N/WR1N data bus.
// The CPU pushes into a TX FIFO and pops from an RX FIFO; status and control registers sit alongside.
module bus_mailbox_target #(
   parameter logic [15:0] BASE_ADDR = 16'hFF10,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AW        = 3
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic [15:0] ADDR,
   input  logic [15:0] DIN,
   output logic [15:0] DOUT,
   input  logic        RDN,
   input  logic        WR0N,
   input  logic        WR1N,
   output logic [15:0] TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   input  logic [15:0] RX_DATA,
   input  logic        RX_VALID,
   output logic        RX_READY,
   output logic        INT
);

   localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

   logic          sel;
   logic [1:0]    off;
   logic          wrn;
   logic          wrn_q, rdn_q;
   logic          wr_arm, rd_arm;
   logic          rd_sel_data;
   logic          wr_ev, rd_fall, rx_pop_req;
   logic [15:0]   wr_word;
   logic          ctrl_wr, sts_wr;
   logic          unused_addr0;

   logic [15:0]   tx_mem [DEPTH];
   logic [AW-1:0] tx_wptr, tx_rptr;
   logic [AW:0]   tx_cnt;
   logic          tx_full, tx_empty, tx_push, tx_pop, tx_push_ok, tx_flush;

   logic [15:0]   rx_mem [DEPTH];
   logic [AW-1:0] rx_wptr, rx_rptr;
   logic [AW:0]   rx_cnt;
   logic          rx_full, rx_empty, rx_push, rx_pop, rx_flush;

   logic          tx_ovf, rx_unf;
   logic [1:0]    ctrl_ie;
   logic          int_q;
   logic [15:0]   status;

   always_comb begin
      unused_addr0 = ADDR[0];
      sel        = (ADDR[15:3] == BASE_ADDR[15:3]);
      off        = ADDR[2:1];
      wrn        = WR0N & WR1N;
      // The arm flags keep a strobe that was already low at reset release from counting as an edge.
      wr_ev      = wr_arm & wrn_q & ~wrn & sel;
      rd_fall    = rd_arm & rdn_q & ~RDN;
      rx_pop_req = ~rdn_q & RDN & rd_sel_data;
      wr_word    = {(WR1N ? 8'h00 : DIN[15:8]), (WR0N ? 8'h00 : DIN[7:0])};
      ctrl_wr    = wr_ev & (off == 2'd2);
      sts_wr     = wr_ev & (off == 2'd1) & ~WR0N;
      tx_flush   = ctrl_wr & ~WR0N & DIN[2];
      rx_flush   = ctrl_wr & ~WR0N & DIN[3];

      tx_full    = (tx_cnt == CNT_FULL);
      tx_empty   = (tx_cnt == '0);
      rx_full    = (rx_cnt == CNT_FULL);
      rx_empty   = (rx_cnt == '0);

      tx_push    = wr_ev & (off == 2'd0);
      tx_pop     = ~tx_empty & TX_READY;
      tx_push_ok = tx_push & (~tx_full | tx_pop);
      rx_push    = RX_VALID & ~rx_full;
      rx_pop     = rx_pop_req & ~rx_empty;

      status     = {4'(rx_cnt), 6'b0, rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};
   end

   always_comb begin
      DOUT = '0;
      if (!RDN && sel) begin
         case (off)
            2'd0:    DOUT = rx_empty ? 16'h0000 : rx_mem[rx_rptr];
            2'd1:    DOUT = status;
            2'd2:    DOUT = {14'b0, ctrl_ie};
            default: DOUT = '0;
         endcase
      end
   end

   assign TX_DATA  = tx_mem[tx_rptr];
   assign TX_VALID = ~tx_empty;
   assign RX_READY = ~rx_full;
   assign INT      = int_q;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wrn_q       <= 1'b1;
         rdn_q       <= 1'b1;
         wr_arm      <= 1'b0;
         rd_arm      <= 1'b0;
         rd_sel_data <= 1'b0;
      end else begin
         wrn_q <= wrn;
         rdn_q <= RDN;
         if (wrn) wr_arm <= 1'b1;
         if (RDN) rd_arm <= 1'b1;
         if (rd_fall) rd_sel_data <= sel && (off == 2'd0);
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         tx_ovf  <= 1'b0;
         rx_unf  <= 1'b0;
         ctrl_ie <= '0;
         int_q   <= 1'b0;
      end else begin
         if (sts_wr && DIN[4]) tx_ovf <= 1'b0;
         if (sts_wr && DIN[5]) rx_unf <= 1'b0;
         if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
         if (rx_pop_req && rx_empty) rx_unf <= 1'b1;
         if (ctrl_wr && !WR0N) ctrl_ie <= DIN[1:0];
         int_q <= (ctrl_ie[0] & tx_empty) | (ctrl_ie[1] & ~rx_empty);
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         tx_cnt  <= '0;
      end else if (tx_flush) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         tx_cnt  <= '0;
      end else begin
         if (tx_push_ok) tx_wptr <= tx_wptr + 1'b1;
         if (tx_pop)     tx_rptr <= tx_rptr + 1'b1;
         case ({tx_push_ok, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + 1'b1;
            2'b01:   tx_cnt <= tx_cnt - 1'b1;
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         rx_wptr <= '0;
         rx_rptr <= '0;
         rx_cnt  <= '0;
      end else if (rx_flush) begin
         rx_wptr <= '0;
         rx_rptr <= '0;
         rx_cnt  <= '0;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + 1'b1;
         if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + 1'b1;
            2'b01:   rx_cnt <= rx_cnt - 1'b1;
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   // FIFO storage carries no reset; empty/full flags guard every read.
   always_ff @(posedge CLK) begin
      if (tx_push_ok && !tx_flush) tx_mem[tx_wptr] <= wr_word;
      if (rx_push && !rx_flush)    rx_mem[rx_wptr] <= RX_DATA;
   end

endmodule

// File: tb/tb_bus_mailbox_target.sv
// Directed bench for bus_mailbox_target: reset, TX/RX FIFOs, simultaneous ops, interrupt/flush, decode.
module tb_bus_mailbox_target;

   localparam logic [15:0] BASE = 16'hFF10;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b0;
   logic [15:0] ADDR = '0;
   logic [15:0] DIN = '0;
   logic [15:0] DOUT;
   logic        RDN = 1'b1;
   logic        WR0N = 1'b1;
   logic        WR1N = 1'b1;
   logic [15:0] TX_DATA;
   logic        TX_VALID;
   logic        TX_READY = 1'b0;
   logic [15:0] RX_DATA = '0;
   logic        RX_VALID = 1'b0;
   logic        RX_READY;
   logic        INT;

   int checks = 0;
   int errors = 0;

   bus_mailbox_target #(.BASE_ADDR(16'hFF10), .DEPTH(8), .AW(3)) dut (
      .CLK(CLK), .RESETN(RESETN), .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT),
      .RDN(RDN), .WR0N(WR0N), .WR1N(WR1N),
      .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY), .INT(INT)
   );

   always #5 CLK = ~CLK;

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input logic lo, input logic hi);
      @(negedge CLK);
      ADDR = a; DIN = d; WR0N = ~lo; WR1N = ~hi;
      @(negedge CLK);
      WR0N = 1'b1; WR1N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
      @(negedge CLK);
      ADDR = a; RDN = 1'b0;
      @(negedge CLK);
      d = DOUT;
      RDN = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_reset;
      logic [15:0] r;
      repeat (2) @(negedge CLK);
      RESETN = 1'b1;
      repeat (2) @(negedge CLK);
      ADDR = BASE; DIN = 16'h1234; WR0N = 1'b0;
      @(negedge CLK);
      RESETN = 1'b0;
      #1;
      checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", TX_VALID); end
      checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL rst_rx_ready got %b exp 1", RX_READY); end
      checks++; if (DOUT !== 16'h0000) begin errors++; $display("FAIL rst_dout got %h exp 0000", DOUT); end
      repeat (2) @(negedge CLK);
      RESETN = 1'b1;
      repeat (3) @(negedge CLK);
      checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL held_strobe_push got %b exp 0", TX_VALID); end
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL rst_int got %b exp 0", INT); end
      checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL post_rst_rx_ready got %b exp 1", RX_READY); end
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h000A) begin errors++; $display("FAIL rst_status got %h exp 000a", r); end
      checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL held_strobe_push2 got %b exp 0", TX_VALID); end
      ADDR = BASE; WR0N = 1'b1;
      @(negedge CLK);
      WR0N = 1'b0;
      @(negedge CLK);
      WR0N = 1'b1;
      checks++; if (TX_VALID !== 1'b1) begin errors++; $display("FAIL fresh_strobe_push got %b exp 1", TX_VALID); end
      checks++; if (TX_DATA !== 16'h0034) begin errors++; $display("FAIL fresh_strobe_data got %h exp 0034", TX_DATA); end
      cpu_write(BASE + 16'h4, 16'h0004, 1'b1, 1'b0);
      checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL tx_flush got %b exp 0", TX_VALID); end
      cpu_read(BASE + 16'h4, r);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL ctrl_after_flush got %h exp 0000", r); end
   endtask

   task automatic test_tx_fill;
      logic [15:0] r;
      TX_READY = 1'b0;
      for (int i = 0; i < 9; i++) cpu_write(BASE, 16'h1000 + 16'(i), 1'b1, 1'b1);
      cpu_write(BASE, 16'h00AB, 1'b1, 1'b0);
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h0019) begin errors++; $display("FAIL tx_full_status got %h exp 0019", r); end
      @(negedge CLK);
      TX_READY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (TX_VALID !== 1'b1 || TX_DATA !== 16'h1000 + 16'(i)) begin
            errors++; $display("FAIL tx_drain[%0d] got v=%b %h exp v=1 %h", i, TX_VALID, TX_DATA, 16'h1000 + 16'(i));
         end
         @(negedge CLK);
      end
      checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL tx_drained got %b exp 0", TX_VALID); end
      TX_READY = 1'b0;
      cpu_write(BASE + 16'h2, 16'h0010, 1'b1, 1'b1);
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h000A) begin errors++; $display("FAIL tx_ovf_clear got %h exp 000a", r); end
   endtask

   task automatic test_rx_read;
      logic [15:0] r;
      @(negedge CLK);
      RX_VALID = 1'b1; RX_DATA = 16'hBEEF;
      @(negedge CLK);
      RX_DATA = 16'hCAFE;
      @(negedge CLK);
      RX_VALID = 1'b0;
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h2002) begin errors++; $display("FAIL rx_count2 got %h exp 2002", r); end
      cpu_read(BASE, r);
      checks++; if (r !== 16'hBEEF) begin errors++; $display("FAIL rx_read1 got %h exp beef", r); end
      cpu_read(BASE, r);
      checks++; if (r !== 16'hCAFE) begin errors++; $display("FAIL rx_read2 got %h exp cafe", r); end
      cpu_read(BASE, r);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rx_read_empty got %h exp 0000", r); end
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h002A) begin errors++; $display("FAIL rx_unf_set got %h exp 002a", r); end
      cpu_write(BASE + 16'h2, 16'h0020, 1'b1, 1'b1);
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h000A) begin errors++; $display("FAIL rx_unf_clear got %h exp 000a", r); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] r;
      @(negedge CLK);
      RX_VALID = 1'b1;
      for (int i = 0; i < 8; i++) begin
         RX_DATA = 16'h2000 + 16'(i);
         @(negedge CLK);
      end
      RX_DATA = 16'h2AAA;
      checks++; if (RX_READY !== 1'b0) begin errors++; $display("FAIL rx_full_ready got %b exp 0", RX_READY); end
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h8006) begin errors++; $display("FAIL rx_full_status got %h exp 8006", r); end
      cpu_read(BASE, r);
      checks++; if (r !== 16'h2000) begin errors++; $display("FAIL rx_full_pop got %h exp 2000", r); end
      checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL rx_ready_gap got %b exp 1", RX_READY); end
      @(negedge CLK);
      checks++; if (RX_READY !== 1'b0) begin errors++; $display("FAIL rx_refill got %b exp 0", RX_READY); end
      RX_VALID = 1'b0;
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h8006) begin errors++; $display("FAIL rx_count_kept got %h exp 8006", r); end
      for (int i = 1; i < 9; i++) begin
         cpu_read(BASE, r);
         checks++;
         if (r !== ((i == 8) ? 16'h2AAA : 16'h2000 + 16'(i))) begin
            errors++; $display("FAIL rx_order[%0d] got %h exp %h", i, r, (i == 8) ? 16'h2AAA : 16'h2000 + 16'(i));
         end
      end
      for (int i = 0; i < 8; i++) cpu_write(BASE, 16'h3000 + 16'(i), 1'b1, 1'b1);
      @(negedge CLK);
      ADDR = BASE; DIN = 16'h3008; WR0N = 1'b0; WR1N = 1'b0; TX_READY = 1'b1;
      @(negedge CLK);
      WR0N = 1'b1; WR1N = 1'b1; TX_READY = 1'b0;
      checks++; if (TX_DATA !== 16'h3001) begin errors++; $display("FAIL tx_simul_head got %h exp 3001", TX_DATA); end
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h0009) begin errors++; $display("FAIL tx_simul_status got %h exp 0009", r); end
      TX_READY = 1'b1;
      for (int i = 1; i < 9; i++) begin
         checks++;
         if (TX_DATA !== 16'h3000 + 16'(i)) begin
            errors++; $display("FAIL tx_simul_drain[%0d] got %h exp %h", i, TX_DATA, 16'h3000 + 16'(i));
         end
         @(negedge CLK);
      end
      TX_READY = 1'b0;
      checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL tx_simul_empty got %b exp 0", TX_VALID); end
   endtask

   task automatic test_int_flush;
      logic [15:0] r;
      cpu_write(BASE + 16'h4, 16'h0002, 1'b1, 1'b1);
      cpu_read(BASE + 16'h4, r);
      checks++; if (r !== 16'h0002) begin errors++; $display("FAIL ctrl_rd got %h exp 0002", r); end
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL int_idle got %b exp 0", INT); end
      RX_VALID = 1'b1; RX_DATA = 16'h5555;
      @(negedge CLK);
      RX_VALID = 1'b0;
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL int_lag got %b exp 0", INT); end
      @(negedge CLK);
      checks++; if (INT !== 1'b1) begin errors++; $display("FAIL int_rxne got %b exp 1", INT); end
      ADDR = BASE + 16'h4; DIN = 16'h000A; WR0N = 1'b0; WR1N = 1'b0;
      @(negedge CLK);
      WR0N = 1'b1; WR1N = 1'b1;
      checks++; if (INT !== 1'b1) begin errors++; $display("FAIL int_flush_lag got %b exp 1", INT); end
      @(negedge CLK);
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL int_after_flush got %b exp 0", INT); end
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h000A) begin errors++; $display("FAIL rx_flushed got %h exp 000a", r); end
      cpu_read(BASE + 16'h4, r);
      checks++; if (r !== 16'h0002) begin errors++; $display("FAIL ctrl_after_rxflush got %h exp 0002", r); end
      cpu_write(BASE + 16'h4, 16'h0001, 1'b1, 1'b1);
      checks++; if (INT !== 1'b1) begin errors++; $display("FAIL int_txe got %b exp 1", INT); end
      cpu_write(BASE + 16'h4, 16'h0000, 1'b1, 1'b1);
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL int_off got %b exp 0", INT); end
   endtask

   task automatic test_decode;
      logic [15:0] r;
      cpu_write(BASE + 16'h8, 16'h7777, 1'b1, 1'b1);
      checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL decode_wr got %b exp 0", TX_VALID); end
      @(negedge CLK);
      RX_VALID = 1'b1; RX_DATA = 16'h6666;
      @(negedge CLK);
      RX_VALID = 1'b0;
      cpu_read(BASE + 16'h8, r);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL decode_rd got %h exp 0000", r); end
      cpu_read(BASE + 16'h2, r);
      checks++; if (r !== 16'h1002) begin errors++; $display("FAIL decode_no_pop got %h exp 1002", r); end
      cpu_read(BASE + 16'h6, r);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL off3_rd got %h exp 0000", r); end
      cpu_write(BASE + 16'h6, 16'h00FF, 1'b1, 1'b1);
      cpu_read(BASE + 16'h3, r);
      checks++; if (r !== 16'h1002) begin errors++; $display("FAIL addr0_ignored got %h exp 1002", r); end
      cpu_read(BASE + 16'h4, r);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL off3_wr_ignored got %h exp 0000", r); end
      cpu_read(BASE, r);
      checks++; if (r !== 16'h6666) begin errors++; $display("FAIL decode_data got %h exp 6666", r); end
   endtask

   initial begin
      test_reset;
      test_tx_fill;
      test_rx_read;
      test_back_to_back;
      test_int_flush;
      test_decode;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
